// File: rtl/tse_ssram_bridge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tse_ssram_bridge_arbiter
//  Purpose  : Two-master Avalon-MM arbiter in front of the SSRAM clock-crossing
//             bridge slave port (slave_clk side). Master 0 is the Nios II data
//             master, master 1 is the video frame-reader DMA. Round-robin grant
//             with a per-grant hold limit; read responses are steered back to
//             the issuing master through an in-order ID FIFO, and new reads
//             are throttled once MAX_OUTSTANDING reads are pending.
//  Ports    : slave_clk / slave_reset_n   clock, async active-low reset
//             m0_* / m1_*                  Avalon-MM slave side for each master
//             br_*                         Avalon-MM master side to the bridge
//             outstanding                  pending read count (FIFO occupancy)
//             protocol_error               sticky: response with no pending read
//  Revision : 1.0  initial release
// ============================================================================
module tse_ssram_bridge_arbiter #(
    parameter int ADDR_W          = 23,
    parameter int MAX_HOLD        = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic              slave_clk,
    input  logic              slave_reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] br_address,
    output logic [ADDR_W-1:0] br_nativeaddress,
    output logic [3:0]        br_byteenable,
    output logic              br_read,
    output logic              br_write,
    output logic [31:0]       br_writedata,
    input  logic              br_waitrequest,
    input  logic [31:0]       br_readdata,
    input  logic              br_readdatavalid,
    input  logic              br_endofpacket,
    output logic [4:0]        outstanding,
    output logic              protocol_error
);

    localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [4:0]        c_MAX_OUT  = 5'(MAX_OUTSTANDING);
    localparam logic [HOLD_W-1:0] c_MAX_HOLD = HOLD_W'(MAX_HOLD);
    localparam logic [PTR_W-1:0]  c_PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_ptr, w_ptr_nxt;          // 0 favours m0 in IDLE
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic               r_fifo [MAX_OUTSTANDING];  // grant ID per pending read
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [4:0]         r_count;
    logic               r_protocol_error;

    logic w_req0, w_req1, w_gnt1, w_granted, w_cur_req, w_oth_req;
    logic w_sel_read, w_sel_write, w_pop, w_push, w_full, w_rd_block;
    logic w_accept, w_head;
    logic w_unused_eop;

    assign w_unused_eop = br_endofpacket;

    assign w_req0    = m0_read | m0_write;
    assign w_req1    = m1_read | m1_write;
    assign w_gnt1    = (r_state == GNT1);
    assign w_granted = (r_state != IDLE);
    assign w_cur_req = w_gnt1 ? w_req1 : w_req0;
    assign w_oth_req = w_gnt1 ? w_req0 : w_req1;

    // Command path: plain mux of the granted master (m0 when idle; the
    // strobes are gated off there so the mux value is irrelevant).
    assign w_sel_read       = w_gnt1 ? m1_read       : m0_read;
    assign w_sel_write      = w_gnt1 ? m1_write      : m0_write;
    assign br_address       = w_gnt1 ? m1_address    : m0_address;
    assign br_nativeaddress = br_address;
    assign br_byteenable    = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign br_writedata     = w_gnt1 ? m1_writedata  : m0_writedata;

    assign w_pop  = br_readdatavalid & (r_count != 5'd0);
    assign w_full = (r_count == c_MAX_OUT);
    // A response popping in the same cycle frees a slot, so a read that is
    // waiting on a full FIFO is accepted in that very cycle.
    assign w_rd_block = w_full & ~w_pop;

    assign br_read  = w_granted & w_sel_read & ~w_rd_block;
    assign br_write = w_granted & w_sel_write;
    assign w_accept = (br_read | br_write) & ~br_waitrequest;
    assign w_push   = w_accept & br_read;

    assign m0_waitrequest = ~(w_accept & (r_state == GNT0));
    assign m1_waitrequest = ~(w_accept & w_gnt1);

    assign w_head           = r_fifo[r_rd_ptr];
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop &  w_head;
    assign m0_readdata      = br_readdata;
    assign m1_readdata      = br_readdata;

    assign outstanding    = r_count;
    assign protocol_error = r_protocol_error;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                if (w_req0 && (!w_req1 || !r_ptr))
                    w_state_nxt = GNT0;
                else if (w_req1)
                    w_state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (w_accept) begin
                    w_ptr_nxt = ~w_gnt1;
                    if (w_oth_req) begin
                        // Hand over whenever the other master waits; this
                        // also covers reaching the hold limit.
                        w_state_nxt = w_gnt1 ? GNT0 : GNT1;
                        w_hold_nxt  = '0;
                    end else if (r_hold != c_MAX_HOLD) begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end else if (!w_cur_req) begin
                    // Request withdrawn without an accept.
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            r_state          <= IDLE;
            r_ptr            <= 1'b0;
            r_hold           <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= 5'd0;
            r_protocol_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + 5'd1;
            else if (w_pop && !w_push)
                r_count <= r_count - 5'd1;
            if (br_readdatavalid && (r_count == 5'd0))
                r_protocol_error <= 1'b1;
        end
    end

    // ID storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge slave_clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_gnt1;
    end

endmodule
`default_nettype wire

// File: tb/tb_tse_ssram_bridge_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tse_ssram_bridge_arbiter
//  Purpose  : Self-checking bench for tse_ssram_bridge_arbiter. A transaction
//             level model (grant owner, pending-read ID queue, sticky error)
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tse_ssram_bridge_arbiter;

    localparam int AW = 23;
    localparam int MO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [3:0]    be0 = 4'hF, be1 = 4'h3;
    logic          rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
    logic [31:0]   wd0 = 32'h0, wd1 = 32'h0;
    logic          bwait = 0, brdv = 0, beop = 0;
    logic [31:0]   brd = 32'h0;

    logic          m0_wait, m0_rdv, m1_wait, m1_rdv;
    logic [31:0]   m0_rdata, m1_rdata, br_wdata;
    logic [AW-1:0] br_addr, br_naddr;
    logic [3:0]    br_be;
    logic          br_rd, br_wr, perr_o;
    logic [4:0]    outst;

    always #5 clk = ~clk;

    tse_ssram_bridge_arbiter #(.ADDR_W(AW), .MAX_HOLD(4), .MAX_OUTSTANDING(MO)) dut (
        .slave_clk(clk), .slave_reset_n(rst_n),
        .m0_address(a0), .m0_byteenable(be0), .m0_read(rd0), .m0_write(wr0),
        .m0_writedata(wd0), .m0_waitrequest(m0_wait), .m0_readdata(m0_rdata),
        .m0_readdatavalid(m0_rdv),
        .m1_address(a1), .m1_byteenable(be1), .m1_read(rd1), .m1_write(wr1),
        .m1_writedata(wd1), .m1_waitrequest(m1_wait), .m1_readdata(m1_rdata),
        .m1_readdatavalid(m1_rdv),
        .br_address(br_addr), .br_nativeaddress(br_naddr), .br_byteenable(br_be),
        .br_read(br_rd), .br_write(br_wr), .br_writedata(br_wdata),
        .br_waitrequest(bwait), .br_readdata(brd), .br_readdatavalid(brdv),
        .br_endofpacket(beop), .outstanding(outst), .protocol_error(perr_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + observation logs -----------------
    int  g = -1;          // owner of the grant, -1 = nobody
    int  ptr = 0;         // master favoured on a tie
    int  q[$];            // IDs of pending reads, oldest first
    bit  perr = 0;
    int  wlog[$];         // source of each accepted write
    int  rvlog[$];        // destination of each read response
    int  rdlog[$];        // data seen with each read response
    int  maxout = 0;
    int  stall = 0;
    bit  rq0, rq1, srd, swr, full, pop, e_rd, e_wr, acc;
    int  head;

    always @(negedge clk) begin
        if (!rst_n) begin
            g = -1; ptr = 0; q.delete(); perr = 0;
            chk("rst_br_read", br_rd, 0);
            chk("rst_br_write", br_wr, 0);
            chk("rst_m0_wait", m0_wait, 1);
            chk("rst_m1_wait", m1_wait, 1);
            chk("rst_m0_rdv", m0_rdv, 0);
            chk("rst_m1_rdv", m1_rdv, 0);
            chk("rst_outstanding", outst, 0);
            chk("rst_perr", perr_o, 0);
        end else begin
            rq0  = rd0 | wr0;
            rq1  = rd1 | wr1;
            srd  = (g == 1) ? rd1 : rd0;
            swr  = (g == 1) ? wr1 : wr0;
            full = (q.size() == MO);
            pop  = brdv && (q.size() != 0);
            head = pop ? q[0] : -1;
            e_rd = (g >= 0) && srd && !(full && !pop);
            e_wr = (g >= 0) && swr;
            acc  = (e_rd || e_wr) && !bwait;

            chk("br_read", br_rd, e_rd);
            chk("br_write", br_wr, e_wr);
            chk("m0_wait", m0_wait, !(acc && g == 0));
            chk("m1_wait", m1_wait, !(acc && g == 1));
            chk("m0_rdv", m0_rdv, head == 0);
            chk("m1_rdv", m1_rdv, head == 1);
            chk("m0_rdata", m0_rdata, brd);
            chk("m1_rdata", m1_rdata, brd);
            chk("outstanding", outst, q.size());
            chk("perr", perr_o, perr);
            if (e_rd || e_wr) begin
                chk("br_addr", br_addr, (g == 1) ? a1 : a0);
                chk("br_naddr", br_naddr, (g == 1) ? a1 : a0);
                chk("br_be", br_be, (g == 1) ? be1 : be0);
            end
            if (e_wr)
                chk("br_wdata", br_wdata, (g == 1) ? wd1 : wd0);

            if (br_wr && !m0_wait) wlog.push_back(0);
            if (br_wr && !m1_wait) wlog.push_back(1);
            if (m0_rdv) begin rvlog.push_back(0); rdlog.push_back(int'(m0_rdata)); end
            if (m1_rdv) begin rvlog.push_back(1); rdlog.push_back(int'(m1_rdata)); end
            if (int'(outst) > maxout) maxout = int'(outst);
            if (br_rd && bwait && m1_wait && m0_wait) stall++;

            if (pop) void'(q.pop_front());
            else if (brdv) perr = 1;
            if (acc && e_rd) q.push_back(g);
            if (g < 0) begin
                if (rq0 && (!rq1 || ptr == 0)) g = 0;
                else if (rq1) g = 1;
            end else if (acc) begin
                ptr = 1 - g;
                if ((g == 0) ? rq1 : rq0) g = 1 - g;
            end else if (!((g == 0) ? rq0 : rq1)) begin
                g = -1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        brdv = 1;
        for (int i = 0; i < n; i++) begin
            brd = 32'hD000 + i;
            tick;
        end
        brdv = 0;
    endtask

    task automatic do_reset;
        rst_n = 0;
        tick;
        tick;
        rst_n = 1;
    endtask

    int exp_seq[4];

    initial begin
        tick;
        tick;
        rst_n = 1;
        tick;

        // ---- m0 alone: three back-to-back reads ----
        maxout = 0;
        rd0 = 1; a0 = 23'd100;
        #1 chk("lat_idle_no_read", br_rd, 0);
        tick;
        chk("lat_first_read", br_rd, 1);
        tick; a0 = 23'd101;
        tick; a0 = 23'd102;
        tick; rd0 = 0;
        chk("t1_outstanding3", outst, 3);
        tick;
        brdv = 1; brd = 32'hA0; tick;
        brd = 32'hA1; tick;
        brd = 32'hA2; tick;
        brdv = 0;
        chk("t1_peak", maxout, 3);
        chk("t1_outstanding0", outst, 0);
        chk("t1_nvalid", rvlog.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_dest", (i < rvlog.size()) ? rvlog[i] : 9, 0);
            chk("t1_data", (i < rdlog.size()) ? rdlog[i] : 0, 32'hA0 + i);
        end

        // ---- both masters stream writes: strict alternation ----
        do_reset;
        wlog.delete();
        wr0 = 1; wr1 = 1; wd0 = 32'h1111_0000; wd1 = 32'h2222_0000; a0 = 23'd7; a1 = 23'd9;
        for (int i = 0; i < 8; i++) begin
            wd0 = 32'h1111_0000 + i; wd1 = 32'h2222_0000 + i;
            tick;
        end
        wr0 = 0; wr1 = 0;
        tick;
        exp_seq = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++)
            chk("t2_alternate", (i < wlog.size()) ? wlog[i] : 9, exp_seq[i]);

        // ---- bridge stall while m1 holds the grant with a read ----
        stall = 0;
        rd1 = 1; a1 = 23'd200; bwait = 1;
        tick;
        wr0 = 1; wd0 = 32'hCAFE_0001; a0 = 23'd55;
        repeat (5) tick;
        chk("t3_still_m1", m0_wait, 1);
        bwait = 0;
        #1 chk("t3_accept_c6", m1_wait, 0);
        tick;
        rd1 = 0;
        tick;
        wr0 = 0;
        tick;
        chk("t3_stall_cycles", stall, 5);
        drain(1);

        // ---- read throttling at MAX_OUTSTANDING ----
        rd1 = 1; a1 = 23'd300;
        tick;
        for (int k = 0; k < 16; k++) begin
            a1 = 23'(300 + k);
            tick;
        end
        rd1 = 0;
        tick;
        rd1 = 1; a1 = 23'd400; wr0 = 1; wd0 = 32'hBEEF_0002;
        tick;
        chk("t4_write_goes", m0_wait, 0);
        tick;
        wr0 = 0;
        chk("t4_blocked_read", br_rd, 0);
        chk("t4_blocked_wait", m1_wait, 1);
        chk("t4_full", outst, 16);
        tick;
        brdv = 1; brd = 32'h5555;
        #1 chk("t4_read_on_pop", br_rd, 1);
        chk("t4_wait_on_pop", m1_wait, 0);
        tick;
        brdv = 0; rd1 = 0;
        chk("t4_still16", outst, 16);
        tick;
        drain(16);
        chk("t4_drained", outst, 0);

        // ---- interleaved reads m0,m1,m1,m0 ----
        rvlog.delete(); rdlog.delete();
        rd0 = 1; a0 = 23'd500;
        tick;
        rd1 = 1; a1 = 23'd600;
        tick;
        rd0 = 0;
        tick;
        a1 = 23'd601; rd0 = 1; a0 = 23'd501;
        tick;
        rd1 = 0;
        tick;
        rd0 = 0;
        tick;
        chk("t5_outstanding4", outst, 4);
        brdv = 1;
        for (int i = 0; i < 4; i++) begin
            brd = 32'hE0 + i;
            tick;
        end
        brdv = 0;
        exp_seq = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            chk("t5_dest", (i < rvlog.size()) ? rvlog[i] : 9, exp_seq[i]);
            chk("t5_data", (i < rdlog.size()) ? rdlog[i] : 0, 32'hE0 + i);
        end

        // ---- response with nothing pending ----
        brdv = 1; brd = 32'hBAD;
        #1 chk("t6_no_m0_rdv", m0_rdv, 0);
        chk("t6_no_m1_rdv", m1_rdv, 0);
        tick;
        brdv = 0;
        chk("t6_perr_set", perr_o, 1);
        repeat (3) tick;
        chk("t6_perr_held", perr_o, 1);

        // ---- asynchronous reset mid-burst ----
        rd0 = 1; wr1 = 1; a0 = 23'd700;
        tick; tick; tick;
        brdv = 1;
        #1 rst_n = 0;
        #1 chk("ar_br_read", br_rd, 0);
        chk("ar_br_write", br_wr, 0);
        chk("ar_m0_wait", m0_wait, 1);
        chk("ar_m1_wait", m1_wait, 1);
        chk("ar_m0_rdv", m0_rdv, 0);
        chk("ar_outstanding", outst, 0);
        chk("ar_perr", perr_o, 0);
        rd0 = 0; wr1 = 0; brdv = 0;
        tick;
        rst_n = 1;
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
